// File: rtl/m68040_bus_pkg.sv
// Shared definitions for the MC68040 bus initiator: SIZ codes, FSM encoding and
// beat helpers.
package m68040_bus_pkg;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam int unsigned LINE_BEATS = 4;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StStart,
        StData,
        StRelease
    } bus_state_e;

    function automatic logic is_line(input logic [1:0] siz);
        return siz == SIZ_LINE;
    endfunction

    function automatic logic [2:0] siz_beats(input logic [1:0] siz);
        logic [2:0] beats;
        unique case (siz)
            SIZ_LONG: beats = 3'd1;
            SIZ_BYTE: beats = 3'd1;
            SIZ_WORD: beats = 3'd1;
            SIZ_LINE: beats = 3'(LINE_BEATS);
            default:  beats = 3'd1;
        endcase
        return beats;
    endfunction

    // Lines wrap within the 16-byte line, so the index is modulo 4.
    function automatic logic [1:0] beat_index(input logic [1:0] start_lw, input logic [1:0] beat);
        return start_lw + beat;
    endfunction

endpackage

// File: rtl/m68040_bus_initiator_if.sv
// MC68040 bus-side signals of the initiator; master is the initiator, slave is the
// responder/arbiter side.
interface m68040_bus_initiator_if;

    logic        nBR;
    logic        nBG;
    logic        nBB_IN;
    logic        nBB_OUT;
    logic        nBB_OE;
    logic        nTS;
    logic        nTIP;
    logic [31:0] A_OUT;
    logic        A_OE;
    logic [1:0]  SIZ;
    logic        RnW;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic [31:0] D_IN;
    logic        nTA;
    logic        nTEA;
    logic        nTBI;

    modport master (
        output nBR, nBB_OUT, nBB_OE, nTS, nTIP, A_OUT, A_OE, SIZ, RnW, D_OUT, D_OE,
        input  nBG, nBB_IN, D_IN, nTA, nTEA, nTBI
    );

    modport slave (
        input  nBR, nBB_OUT, nBB_OE, nTS, nTIP, A_OUT, A_OE, SIZ, RnW, D_OUT, D_OE,
        output nBG, nBB_IN, D_IN, nTA, nTEA, nTBI
    );

endinterface

// File: rtl/m68040_bus_arbiter_req.sv
// Bus request/grant/busy handshake: drives _BR while arbitrating, owns _BB during the
// transfer and drives it high for BB_RELEASE_CYCLES before tristating.
module m68040_bus_arbiter_req #(
    parameter int unsigned BB_RELEASE_CYCLES = 1
) (
    input  logic CLK40,
    input  logic nRESET,
    input  logic arb,
    input  logic own,
    input  logic rel,
    input  logic nBG,
    input  logic nBB_IN,
    output logic nBR,
    output logic nBB_OUT,
    output logic nBB_OE,
    output logic granted,
    output logic rel_done
);

    localparam int unsigned RelW = (BB_RELEASE_CYCLES > 1) ? $clog2(BB_RELEASE_CYCLES) : 1;

    logic [RelW-1:0] rel_cnt_q, rel_cnt_d;

    // Grant counts only when the previous master has also let go of _BB.
    assign granted  = arb && !nBG && nBB_IN;
    assign nBR      = !arb;
    assign nBB_OUT  = !own;
    assign nBB_OE   = own || rel;
    assign rel_done = rel && (rel_cnt_q == RelW'(BB_RELEASE_CYCLES - 1));

    always_comb begin
        rel_cnt_d = '0;
        if (rel && !rel_done) begin
            rel_cnt_d = rel_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK40) begin
        if (!nRESET) begin
            rel_cnt_q <= '0;
        end else begin
            rel_cnt_q <= rel_cnt_d;
        end
    end

endmodule

// File: rtl/m68040_bus_initiator.sv
// MC68040 bus initiator: turns a request/done port into arbitrated single or line
// transfers terminated by _TA, _TEA, _TBI or a no-response timeout.
module m68040_bus_initiator
    import m68040_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 255,
    parameter int unsigned BB_RELEASE_CYCLES = 1
) (
    input  logic        CLK40,
    input  logic        nRESET,
    input  logic        REQ,
    input  logic        REQ_RnW,
    input  logic [29:0] REQ_ADDR,
    input  logic [1:0]  REQ_SIZ,
    input  logic [1:0]  REQ_BYTE,
    input  logic [31:0] REQ_WDATA,
    output logic        BEAT_ACK,
    output logic [1:0]  BEAT_IDX,
    output logic [31:0] RDATA,
    output logic        DONE,
    output logic        ERR,
    output logic        TBI_SEEN,
    m68040_bus_initiator_if.master bus
);

    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

    bus_state_e state_q, state_d;

    logic          rnw_q, rnw_d;
    logic [29:0]   addr_q, addr_d;
    logic [1:0]    siz_q, siz_d;
    logic [1:0]    byte_q, byte_d;
    logic [1:0]    beat_cnt_q, beat_cnt_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic          beat_ack_q, beat_ack_d;
    logic [1:0]    beat_idx_q, beat_idx_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tbi_q, tbi_d;

    logic arb, own, rel, granted, rel_done;
    logic line, last_beat;

    assign arb  = (state_q == StArb);
    assign own  = (state_q == StStart) || (state_q == StData);
    assign rel  = (state_q == StRelease);
    assign line = is_line(siz_q);
    assign last_beat = (({1'b0, beat_cnt_q} + 3'd1) == siz_beats(siz_q));

    m68040_bus_arbiter_req #(
        .BB_RELEASE_CYCLES (BB_RELEASE_CYCLES)
    ) u_arbiter (
        .CLK40    (CLK40),
        .nRESET   (nRESET),
        .arb      (arb),
        .own      (own),
        .rel      (rel),
        .nBG      (bus.nBG),
        .nBB_IN   (bus.nBB_IN),
        .nBR      (bus.nBR),
        .nBB_OUT  (bus.nBB_OUT),
        .nBB_OE   (bus.nBB_OE),
        .granted  (granted),
        .rel_done (rel_done)
    );

    always_comb begin
        state_d    = state_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        siz_d      = siz_q;
        byte_d     = byte_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        beat_ack_d = 1'b0;
        beat_idx_d = beat_idx_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tbi_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (REQ) begin
                    rnw_d   = REQ_RnW;
                    addr_d  = REQ_ADDR;
                    siz_d   = REQ_SIZ;
                    // Line transfers are always longword aligned on the bus.
                    byte_d  = is_line(REQ_SIZ) ? 2'b00 : REQ_BYTE;
                    state_d = StArb;
                end
            end
            StArb: begin
                if (granted) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                beat_cnt_d = '0;
                to_cnt_d   = '0;
                state_d    = StData;
            end
            StData: begin
                if (!bus.nTEA) begin
                    state_d = StRelease;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (!bus.nTA) begin
                    beat_ack_d = 1'b1;
                    beat_idx_d = beat_index(addr_q[1:0], beat_cnt_q);
                    rdata_d    = bus.D_IN;
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    to_cnt_d   = '0;
                    if (last_beat) begin
                        state_d = StRelease;
                        done_d  = 1'b1;
                    end else if (line && (beat_cnt_q == 2'd0) && !bus.nTBI) begin
                        state_d = StRelease;
                        done_d  = 1'b1;
                        tbi_d   = 1'b1;
                    end
                end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StRelease;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (rel_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK40) begin
        if (!nRESET) begin
            state_q    <= StIdle;
            rnw_q      <= 1'b1;
            addr_q     <= '0;
            siz_q      <= SIZ_LONG;
            byte_q     <= '0;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            beat_ack_q <= 1'b0;
            beat_idx_q <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tbi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            siz_q      <= siz_d;
            byte_q     <= byte_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            beat_ack_q <= beat_ack_d;
            beat_idx_q <= beat_idx_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tbi_q      <= tbi_d;
        end
    end

    assign bus.nTS   = (state_q != StStart);
    assign bus.nTIP  = !own;
    assign bus.A_OE  = own;
    assign bus.A_OUT = {addr_q, byte_q};
    assign bus.SIZ   = siz_q;
    assign bus.RnW   = rnw_q;
    assign bus.D_OE  = (state_q == StData) && !rnw_q;
    assign bus.D_OUT = REQ_WDATA;

    assign BEAT_ACK = beat_ack_q;
    assign BEAT_IDX = beat_idx_q;
    assign RDATA    = rdata_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign TBI_SEEN = tbi_q;

endmodule

// File: tb/tb_m68040_bus_initiator.sv
// Directed bench for m68040_bus_initiator: acts as arbiter and responder, checking
// handshake timing, beat data, termination flags and reset behaviour.
module tb_m68040_bus_initiator;
    import m68040_bus_pkg::*;

    logic        CLK40 = 1'b0;
    logic        nRESET;
    logic        REQ;
    logic        REQ_RnW;
    logic [29:0] REQ_ADDR;
    logic [1:0]  REQ_SIZ;
    logic [1:0]  REQ_BYTE;
    logic [31:0] REQ_WDATA;
    logic        BEAT_ACK;
    logic [1:0]  BEAT_IDX;
    logic [31:0] RDATA;
    logic        DONE;
    logic        ERR;
    logic        TBI_SEEN;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] ldata [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [1:0]  lidx  [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

    m68040_bus_initiator_if bif ();

    m68040_bus_initiator #(
        .TIMEOUT_CYCLES    (16),
        .BB_RELEASE_CYCLES (1)
    ) dut (
        .CLK40     (CLK40),
        .nRESET    (nRESET),
        .REQ       (REQ),
        .REQ_RnW   (REQ_RnW),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_SIZ   (REQ_SIZ),
        .REQ_BYTE  (REQ_BYTE),
        .REQ_WDATA (REQ_WDATA),
        .BEAT_ACK  (BEAT_ACK),
        .BEAT_IDX  (BEAT_IDX),
        .RDATA     (RDATA),
        .DONE      (DONE),
        .ERR       (ERR),
        .TBI_SEEN  (TBI_SEEN),
        .bus       (bif)
    );

    always #5 CLK40 = ~CLK40;

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk1({tag, "_nBR"}, bif.nBR, 1'b1);
        chk1({tag, "_nTS"}, bif.nTS, 1'b1);
        chk1({tag, "_nTIP"}, bif.nTIP, 1'b1);
        chk1({tag, "_nBB_OUT"}, bif.nBB_OUT, 1'b1);
        chk1({tag, "_nBB_OE"}, bif.nBB_OE, 1'b0);
        chk1({tag, "_A_OE"}, bif.A_OE, 1'b0);
        chk1({tag, "_D_OE"}, bif.D_OE, 1'b0);
        chk1({tag, "_BEAT_ACK"}, BEAT_ACK, 1'b0);
        chk1({tag, "_DONE"}, DONE, 1'b0);
        chk1({tag, "_ERR"}, ERR, 1'b0);
        chk1({tag, "_TBI_SEEN"}, TBI_SEEN, 1'b0);
    endtask

    // Presents a request for one edge; the DUT is in ARB afterwards.
    task automatic issue(input logic [31:0] addr, input logic [1:0] siz, input logic rnw,
                         input logic [31:0] wdata);
        REQ_ADDR  = addr[31:2];
        REQ_BYTE  = addr[1:0];
        REQ_SIZ   = siz;
        REQ_RnW   = rnw;
        REQ_WDATA = wdata;
        REQ       = 1'b1;
        tick();
        REQ       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nRESET     = 1'b0;
        REQ        = 1'b0;
        REQ_RnW    = 1'b1;
        REQ_ADDR   = '0;
        REQ_SIZ    = SIZ_LONG;
        REQ_BYTE   = '0;
        REQ_WDATA  = '0;
        bif.nBG    = 1'b1;
        bif.nBB_IN = 1'b1;
        bif.D_IN   = '0;
        bif.nTA    = 1'b1;
        bif.nTEA   = 1'b1;
        bif.nTBI   = 1'b1;
        tick();
        tick();
        check_reset("rst");
        nRESET = 1'b1;
        tick();

        // Single long read, grant present, two wait states.
        bif.nBG = 1'b0;
        issue(32'h00F80004, SIZ_LONG, 1'b1, 32'h0);
        chk1("t1_nBR_arb", bif.nBR, 1'b0);
        chk1("t1_nTS_arb", bif.nTS, 1'b1);
        tick();
        chk1("t1_nTS_start", bif.nTS, 1'b0);
        chk1("t1_nTIP_start", bif.nTIP, 1'b0);
        chk("t1_A_OUT", bif.A_OUT, 32'h00F80004);
        chk1("t1_A_OE", bif.A_OE, 1'b1);
        chk1("t1_nBB_OE", bif.nBB_OE, 1'b1);
        chk1("t1_nBB_OUT", bif.nBB_OUT, 1'b0);
        chk1("t1_nBR_start", bif.nBR, 1'b1);
        chk1("t1_RnW", bif.RnW, 1'b1);
        chk("t1_SIZ", 32'(bif.SIZ), 32'd0);
        tick();
        chk1("t1_nTS_data", bif.nTS, 1'b1);
        chk1("t1_nTIP_data", bif.nTIP, 1'b0);
        tick();
        chk1("t1_wait1_ack", BEAT_ACK, 1'b0);
        tick();
        chk1("t1_wait2_ack", BEAT_ACK, 1'b0);
        bif.nTA  = 1'b0;
        bif.D_IN = 32'h12345678;
        tick();
        bif.nTA  = 1'b1;
        bif.D_IN = 32'hDEADBEEF;
        chk1("t1_ack", BEAT_ACK, 1'b1);
        chk("t1_rdata", RDATA, 32'h12345678);
        chk("t1_idx", 32'(BEAT_IDX), 32'd1);
        chk1("t1_done", DONE, 1'b1);
        chk1("t1_err", ERR, 1'b0);
        chk1("t1_tbi", TBI_SEEN, 1'b0);
        chk1("t1_nTIP_rel", bif.nTIP, 1'b1);
        chk1("t1_A_OE_rel", bif.A_OE, 1'b0);
        chk1("t1_nBB_OUT_rel", bif.nBB_OUT, 1'b1);
        chk1("t1_nBB_OE_rel", bif.nBB_OE, 1'b1);
        tick();
        chk1("t1_nBB_OE_idle", bif.nBB_OE, 1'b0);
        chk1("t1_done_clr", DONE, 1'b0);
        chk1("t1_ack_clr", BEAT_ACK, 1'b0);

        // Line read at 0x08: wrap order 2,3,0,1; _TBI on beat 1 must be ignored.
        issue(32'h00000008, SIZ_LINE, 1'b1, 32'h0);
        tick();
        chk("t2_A_OUT_start", bif.A_OUT, 32'h00000008);
        chk("t2_SIZ", 32'(bif.SIZ), 32'd3);
        tick();
        for (int b = 0; b < 4; b++) begin
            bif.nTA  = 1'b0;
            bif.nTBI = (b == 1) ? 1'b0 : 1'b1;
            bif.D_IN = ldata[b];
            tick();
            chk1($sformatf("t2_ack%0d", b), BEAT_ACK, 1'b1);
            chk($sformatf("t2_idx%0d", b), 32'(BEAT_IDX), 32'(lidx[b]));
            chk($sformatf("t2_rdata%0d", b), RDATA, ldata[b]);
            chk($sformatf("t2_A_OUT%0d", b), bif.A_OUT, 32'h00000008);
            chk1($sformatf("t2_done%0d", b), DONE, (b == 3));
            chk1($sformatf("t2_nTIP%0d", b), bif.nTIP, (b == 3));
        end
        bif.nTA  = 1'b1;
        bif.nTBI = 1'b1;
        chk1("t2_err", ERR, 1'b0);
        chk1("t2_tbi", TBI_SEEN, 1'b0);
        tick();
        chk1("t2_ack_clr", BEAT_ACK, 1'b0);

        // Line read cut short by _TBI on the first beat.
        issue(32'h00000010, SIZ_LINE, 1'b1, 32'h0);
        tick();
        tick();
        bif.nTA  = 1'b0;
        bif.nTBI = 1'b0;
        bif.D_IN = 32'hCAFEF00D;
        tick();
        bif.nTA  = 1'b1;
        bif.nTBI = 1'b1;
        chk1("t3_ack", BEAT_ACK, 1'b1);
        chk("t3_idx", 32'(BEAT_IDX), 32'd0);
        chk("t3_rdata", RDATA, 32'hCAFEF00D);
        chk1("t3_done", DONE, 1'b1);
        chk1("t3_tbi", TBI_SEEN, 1'b1);
        chk1("t3_err", ERR, 1'b0);
        chk1("t3_nTIP", bif.nTIP, 1'b1);
        tick();
        chk1("t3_ack_clr", BEAT_ACK, 1'b0);

        // Byte write answered by _TEA and _TA together.
        issue(32'h00BFE001, SIZ_BYTE, 1'b0, 32'hA5A5A5A5);
        tick();
        chk("t4_A_OUT", bif.A_OUT, 32'h00BFE001);
        chk("t4_SIZ", 32'(bif.SIZ), 32'd1);
        chk1("t4_RnW", bif.RnW, 1'b0);
        chk1("t4_D_OE_start", bif.D_OE, 1'b0);
        tick();
        chk1("t4_D_OE_data", bif.D_OE, 1'b1);
        chk("t4_D_OUT", bif.D_OUT, 32'hA5A5A5A5);
        bif.nTEA = 1'b0;
        bif.nTA  = 1'b0;
        tick();
        bif.nTEA = 1'b1;
        bif.nTA  = 1'b1;
        chk1("t4_ack", BEAT_ACK, 1'b0);
        chk1("t4_done", DONE, 1'b1);
        chk1("t4_err", ERR, 1'b1);
        chk1("t4_tbi", TBI_SEEN, 1'b0);
        chk1("t4_D_OE_rel", bif.D_OE, 1'b0);
        tick();

        // No responder: timeout 16 cycles after the START cycle.
        issue(32'h00000100, SIZ_LONG, 1'b1, 32'h0);
        tick();
        chk1("t5_nTS_start", bif.nTS, 1'b0);
        tick();
        n = 0;
        while (DONE !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_cycles", 32'(n), 32'd16);
        chk1("t5_err", ERR, 1'b1);
        chk1("t5_ack", BEAT_ACK, 1'b0);
        chk1("t5_nTIP", bif.nTIP, 1'b1);
        chk1("t5_A_OE", bif.A_OE, 1'b0);
        tick();
        chk1("t5_nBB_OE", bif.nBB_OE, 1'b0);

        // Arbitration: no grant for 3 cycles, then grant with _BB busy for 10.
        bif.nBG = 1'b1;
        issue(32'h00000200, SIZ_LONG, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("t6_nogrant_nTS%0d", i), bif.nTS, 1'b1);
            chk1($sformatf("t6_nogrant_nBR%0d", i), bif.nBR, 1'b0);
        end
        bif.nBG    = 1'b0;
        bif.nBB_IN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1($sformatf("t6_busy_nTS%0d", i), bif.nTS, 1'b1);
        end
        bif.nBB_IN = 1'b1;
        tick();
        chk1("t6_nTS_start", bif.nTS, 1'b0);
        tick();
        bif.nTA = 1'b0;
        tick();
        bif.nTA = 1'b1;
        chk1("t6_done", DONE, 1'b1);
        tick();

        // Reset asserted while line beat 2 is pending.
        issue(32'h00000020, SIZ_LINE, 1'b1, 32'h0);
        tick();
        tick();
        bif.nTA = 1'b0;
        tick();
        tick();
        chk("t7_idx_beat1", 32'(BEAT_IDX), 32'd1);
        nRESET = 1'b0;
        tick();
        check_reset("t7");
        chk("t7_idx_clr", 32'(BEAT_IDX), 32'd0);
        nRESET  = 1'b1;
        bif.nTA = 1'b1;
        tick();
        chk1("t7_done_after", DONE, 1'b0);
        chk1("t7_nBR_after", bif.nBR, 1'b1);
        chk1("t7_nTIP_after", bif.nTIP, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/m68040_bus_initiator.md
Name: m68040_bus_initiator

Overview:
- Initiating end of the MC68040 transfer protocol; complements the existing address-decode/_TA responder.
- Gives internal logic (DMA, PCI bridge, test master) a simple request/done port.
- Arbitrates for the bus (_BR/_BG/_BB), issues _TS/_TIP with address/size/direction, and runs single or 4-beat line transfers terminated by _TA or _TEA.
- Handles _TBI, and a timeout when no responder acknowledges.

Parameters:
TIMEOUT_CYCLES, 255, CLK40 cycles in DATA with no _TA/_TEA before the transfer is aborted with error
BB_RELEASE_CYCLES, 1, cycles _BB is driven high before tristating

Ports:
CLK40  in  1  system clock; all logic on rising edge
nRESET  in  1  reset; one clock; reset is synchronous and active-low
REQ  in  1  transfer request, level; sampled in IDLE only
REQ_RnW  in  1  1=read, 0=write
REQ_ADDR  in  30  longword address A[31:2]
REQ_SIZ  in  2  68040 SIZ code (00 long, 01 byte, 10 word, 11 line)
REQ_BYTE  in  2  A[1:0] for byte/word transfers
REQ_WDATA  in  32  write data; held by requester until BEAT_ACK
BEAT_ACK  out  1  one-clock pulse per completed beat
BEAT_IDX  out  2  longword index of current beat within line, (A[3:2]+n) mod 4
RDATA  out  32  read data, valid with BEAT_ACK
DONE  out  1  one-clock pulse at end of transfer
ERR  out  1  valid with DONE: 1 on _TEA or timeout
TBI_SEEN  out  1  valid with DONE: line transfer cut short by _TBI
nBR  out  1  bus request
nBG  in  1  bus grant
nBB_IN  in  1  bus busy, sampled
nBB_OUT, nBB_OE  out  1,1  bus busy drive value/enable
nTS, nTIP  out  1,1  transfer start, transfer in progress
A_OUT  out  32  address; A_OE enables
A_OE  out  1  address/SIZ/RnW drive enable
SIZ  out  2  size
RnW  out  1  direction
D_OUT  out  32  write data; D_OE enables
D_OE  out  1  data drive enable
D_IN  in  32  read data
nTA, nTEA, nTBI  in  1,1,1  transfer ack, error, burst inhibit

Behaviour:
- Reset (nRESET=0 at edge): state IDLE.
  - nBR=nTS=nTIP=nBB_OUT=1; nBB_OE=A_OE=D_OE=0.
  - BEAT_ACK=DONE=ERR=TBI_SEEN=0; counters cleared.
  - Reset mid-transfer abandons the cycle immediately; no DONE.
- States: IDLE -> ARB -> START -> DATA -> RELEASE -> IDLE.
- IDLE:
  - REQ=1: latch request fields.
  - Go to ARB with nBR=0 on the next cycle.
- ARB:
  - Hold nBR=0.
  - When nBG=0 and nBB_IN=1 are sampled on the same edge, go to START.
  - Otherwise wait indefinitely (no timeout in ARB).
- START (exactly one clock):
  - nTS=0, nTIP=0, nBB_OUT=0, nBB_OE=1, A_OE=1.
  - A_OUT={REQ_ADDR,REQ_BYTE}; for lines, A_OUT[1:0]=00.
  - nBR returns to 1.
  - Writes: D_OE=1 from the next cycle.
- DATA:
  - nTS=1, nTIP=0; address, SIZ and RnW held constant for all beats.
  - Beat count = 4 if SIZ=11, else 1.
  - Each edge sampling nTA=0: BEAT_ACK=1 next cycle, RDATA=D_IN captured at that edge, beat counter++.
  - nTEA=0 has priority over nTA when both are sampled: end immediately, ERR=1.
  - nTBI=0 with nTA=0 on beat 0 of a line: end after that beat, TBI_SEEN=1, ERR=0.
  - nTBI ignored on non-line transfers and on beats 1-3.
  - Timeout counter reloads on each beat; reaching TIMEOUT_CYCLES ends the transfer with ERR=1.
- Exit DATA on last beat, error, or TBI:
  - nTIP=1, A_OE=D_OE=0.
  - nBB_OUT=1 held for BB_RELEASE_CYCLES, then nBB_OE=0.
  - DONE pulses in the first RELEASE cycle.
- Back-to-back requests: REQ still high in IDLE starts a new arbitration. No bus parking.
- Latency, single zero-wait-state read with grant already present:
  - REQ edge 0 -> nBR edge 1 -> START edge 2 -> _TA sampled edge 3 -> BEAT_ACK and DONE edge 4.

Decomposition:
- Shared package m68040_bus_pkg:
  - SIZ codes (SIZ_LONG=00, SIZ_BYTE=01, SIZ_WORD=10, SIZ_LINE=11).
  - State enum encoding.
  - LINE_BEATS=4.
- One natural sub-module: m68040_bus_arbiter_req, covering _BR/_BG/_BB request, grant and release handshake.
- The top holds the transfer FSM, beat/timeout counters and data path.

Test Plan:
- Single long read at 0x00F80004; grant at once; _TA after 2 wait states -> nTS low 1 clock; one BEAT_ACK with RDATA=D_IN=0x12345678; DONE, ERR=0; nBB tristated 1 cycle after nTIP rises.
- Line read at 0x00000008 with _TA on 4 consecutive edges -> 4 BEAT_ACKs with BEAT_IDX 2,3,0,1; A_OUT=0x00000008 throughout; DONE after 4th.
- Line read with nTBI=0 on first _TA -> single BEAT_ACK, DONE with TBI_SEEN=1, ERR=0; nTIP high next cycle.
- Byte write 0xA5 at 0x00BFE001 answered by nTEA=0 and nTA=0 together -> no BEAT_ACK, DONE with ERR=1, D_OE drops.
- No responder, TIMEOUT_CYCLES=16 -> DONE with ERR=1 exactly 16 cycles after START, bus released.
- nBB_IN held low 10 cycles after nBG=0 -> no nTS until nBB_IN=1. Separately, nRESET=0 mid line beat 2 -> all outputs at reset values next edge, no DONE.
